msk_rnd_source: RTL and testbench
=================================

# msk_rnd_source

Fresh-randomness transmitter for the masked-gadget datapath: produces NRND bits per handshake for the `rnd_*` inputs of the MSK gadgets (refresh and DOM multiplication). A 64-bit Fibonacci LFSR is seeded externally, warmed up, and then stepped only on consumption, so a random word is never delivered twice. A use counter bounds the output between reseeds and requests a new seed when the budget is exhausted.

## Interface

Parameters:
- NRND, 8, random bits delivered per handshake; legal range 1..64.
- WARMUP, 4, cycles of discarded stepping after every seed load; 0 is legal.
- RESEED_PERIOD, 1024, words delivered per seed before output stalls; 0 means unlimited.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- seed  input  64  seed word.
- seed_valid  input  1  seed offered.
- seed_ready  output  1  seed accepted when seed_valid and seed_ready are both 1 at a rising edge.
- rnd_out  output  NRND  random word, valid while rnd_valid is 1.
- rnd_valid  output  1  rnd_out is fresh.
- rnd_ready  input  1  consumer takes rnd_out when rnd_valid and rnd_ready are both 1 at a rising edge.
- reseed_req  output  1  a seed is needed (unseeded or budget exhausted).

## Operation

- LFSR state S[63:0]. One step: b = S[63]^S[62]^S[60]^S[59]; S <= {S[62:0], b}.
- One word is NRND consecutive steps. rnd_out[i] is the bit b produced by step i of the pending word, computed combinationally from the current S. S advances by NRND steps when a word is consumed.
- Seed load: S <= seed. An all-zero seed is replaced by 64'h1 (LFSR lock-up guard).
- Word counter CNT (width clog2(RESEED_PERIOD+1)): cleared on seed accept, +1 per handshake, saturates at RESEED_PERIOD.
- FSM:
  - UNSEEDED: state after reset. rnd_valid=0, reseed_req=1. Seed accept goes to WARMUP, or to RUN if WARMUP=0.
  - WARMUP: S advances NRND steps every cycle; a cycle counter runs from WARMUP-1 down to 0 and the FSM moves to RUN after WARMUP cycles. rnd_valid=0, reseed_req=0.
  - RUN: rnd_valid = (RESEED_PERIOD==0) || (CNT<RESEED_PERIOD); reseed_req = !rnd_valid. S advances only on a handshake.
- seed_ready is 1 in every state. A seed accepted in WARMUP or RUN restarts the load: S <= seed, CNT <= 0, then WARMUP (or RUN if WARMUP=0).
- Seed accept and rnd handshake in the same cycle: the consumer receives the current rnd_out, and the seed load determines the next S (no step applied). rnd_valid is 0 the next cycle when WARMUP>0.
- Exhausted in RUN: rnd_valid=0 and S frozen until a seed arrives. The last word delivered is never re-presented.

## Timing

- Reset values: rnd_valid=0, reseed_req=1, seed_ready=1, S=0 (so rnd_out=0), CNT=0, FSM=UNSEEDED. Asserting rst mid-operation returns immediately to these values; any word in flight is dropped.
- Seed accepted at edge t: rnd_valid rises after edge t+WARMUP (same cycle as the first RUN cycle), i.e. WARMUP+1 cycles after the accept cycle.
- rnd_out changes only on a handshake or a seed load. rnd_out stays stable while rnd_valid=1 and rnd_ready=0.
- Throughput: one word per cycle while rnd_ready stays high.
- rnd_out and rnd_valid are combinational from registers only; there is no combinational path from rnd_ready or seed_valid to any output.

## Test plan

- Reset, then idle for 10 cycles -> rnd_valid=0, reseed_req=1, seed_ready=1, rnd_out=0 throughout.
- NRND=8, WARMUP=0, seed 64'h8000_0000_0000_0000, rnd_ready=1 -> rnd_valid rises the cycle after accept; words 8'h01 then 8'h00; the full stream matches a bit-serial software model for 1000 words.
- WARMUP=4, seed 64'h1, rnd_ready=0 -> rnd_valid rises exactly 5 cycles after the accept cycle; rnd_out is held constant for 20 stalled cycles; the first word equals the software model's word after 32 discarded steps.
- RESEED_PERIOD=3, continuous rnd_ready -> exactly 3 handshakes, then rnd_valid=0 and reseed_req=1; a new seed restores output with CNT=0.
- Seed of 0 -> same stream as seed 64'h1. Seed accepted in the same cycle as a handshake -> consumer gets the old word, and the next words follow the new seed.
- rst pulsed asynchronously mid-RUN between edges -> outputs take reset values immediately, without waiting for a clock edge; output resumes only after a fresh seed.

Source files
------------

// File: rtl/msk_rnd_source_if.sv
// Handshake bundle between msk_rnd_source and its seed provider / randomness consumer.
//
// Handshake semantics (both channels): a transfer happens at a rising clk edge
// where valid and ready are both 1. The sender holds its payload stable while
// valid=1 and ready=0. Neither valid nor payload may depend combinationally on
// the matching ready.
interface msk_rnd_source_if #(
    parameter int NRND = 8
);
    logic [63:0]     seed;
    logic            seed_valid;
    logic            seed_ready;
    logic [NRND-1:0] rnd_out;
    logic            rnd_valid;
    logic            rnd_ready;
    logic            reseed_req;

    // The randomness source side.
    modport master (
        input  seed, seed_valid, rnd_ready,
        output seed_ready, rnd_out, rnd_valid, reseed_req
    );

    // The seed provider / consumer side.
    modport slave (
        output seed, seed_valid, rnd_ready,
        input  seed_ready, rnd_out, rnd_valid, reseed_req
    );
endinterface

// File: rtl/msk_rnd_source.sv
// Fresh-randomness source for masked gadgets: externally seeded 64-bit
// Fibonacci LFSR, warmed up after each seed, stepped only when a word is
// consumed, with a per-seed word budget that requests a reseed when spent.
module msk_rnd_source #(
    parameter int NRND          = 8,
    parameter int WARMUP        = 4,
    parameter int RESEED_PERIOD = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    msk_rnd_source_if.master        bus,
    output logic [1:0]              dbg_state
);

    localparam int CW        = (RESEED_PERIOD > 0) ? $clog2(RESEED_PERIOD + 1) : 1;
    localparam int WW        = (WARMUP > 1) ? $clog2(WARMUP) : 1;
    localparam int WARM_INIT = (WARMUP > 0) ? WARMUP - 1 : 0;

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [63:0]     lfsr_q, lfsr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WW-1:0]   warm_q, warm_d;

    logic [63:0]     lfsr_adv;
    logic [63:0]     walk;
    logic            fb;
    logic [NRND-1:0] word;
    logic [63:0]     seed_load;
    logic            budget_ok;
    logic            rnd_valid_int;
    logic            hs;

    // Pending word: NRND feedback bits from the current state, plus the state after those steps.
    always_comb begin
        walk = lfsr_q;
        fb   = 1'b0;
        word = '0;
        for (int i = 0; i < NRND; i++) begin
            fb      = walk[63] ^ walk[62] ^ walk[60] ^ walk[59];
            word[i] = fb;
            walk    = {walk[62:0], fb};
        end
        lfsr_adv = walk;
    end

    // Output flags derive from registers only; the all-zero seed would lock the LFSR up.
    always_comb begin
        seed_load     = (bus.seed == 64'd0) ? 64'd1 : bus.seed;
        budget_ok     = (RESEED_PERIOD == 0) || (cnt_q < CW'(RESEED_PERIOD));
        rnd_valid_int = (state_q == ST_RUN) && budget_ok;
        hs            = rnd_valid_int && bus.rnd_ready;
    end

    // Next-state logic: a seed accept overrides any step, including a same-cycle handshake.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        warm_d  = warm_q;
        if (bus.seed_valid) begin
            lfsr_d  = seed_load;
            cnt_d   = '0;
            warm_d  = WW'(WARM_INIT);
            state_d = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
        end else begin
            case (state_q)
                ST_WARMUP: begin
                    lfsr_d = lfsr_adv;
                    if (warm_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        warm_d = warm_q - WW'(1);
                    end
                end
                ST_RUN: begin
                    if (hs) begin
                        lfsr_d = lfsr_adv;
                        if (RESEED_PERIOD != 0) begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_UNSEEDED;
                end
            endcase
        end
    end

    // State registers; reset clears everything so rnd_out reads zero immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_UNSEEDED;
            lfsr_q  <= 64'd0;
            cnt_q   <= '0;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            warm_q  <= warm_d;
        end
    end

    // Outputs: seeds are always welcome; reseed is requested when unseeded or out of budget.
    always_comb begin
        bus.seed_ready = 1'b1;
        bus.rnd_out    = word;
        bus.rnd_valid  = rnd_valid_int;
        bus.reseed_req = (state_q == ST_UNSEEDED) || ((state_q == ST_RUN) && !budget_ok);
        dbg_state      = state_q;
    end

endmodule

// File: tb/tb_msk_rnd_source.sv
// Directed bench for msk_rnd_source: three instances cover no warmup, warmup of 4,
// and a reseed budget of 3. Expected words come from a bit-serial LFSR model.
module tb_msk_rnd_source;

    logic clk;
    logic rst;
    logic [1:0] dbg0, dbg1, dbg2;

    int n_cmp;
    int n_err;

    msk_rnd_source_if #(.NRND(8)) if0 ();
    msk_rnd_source_if #(.NRND(8)) if1 ();
    msk_rnd_source_if #(.NRND(8)) if2 ();

    msk_rnd_source #(.NRND(8), .WARMUP(0), .RESEED_PERIOD(1024)) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0), .dbg_state(dbg0)
    );
    msk_rnd_source #(.NRND(8), .WARMUP(4), .RESEED_PERIOD(1024)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1), .dbg_state(dbg1)
    );
    msk_rnd_source #(.NRND(8), .WARMUP(0), .RESEED_PERIOD(3)) u_dut2 (
        .clk(clk), .rst(rst), .bus(if2), .dbg_state(dbg2)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Checker
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit-serial reference model
    function automatic logic [7:0] mdl_word(input logic [63:0] s);
        logic [63:0] w;
        logic        b;
        logic [7:0]  r;
        w = s;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            b    = w[63] ^ w[62] ^ w[60] ^ w[59];
            r[i] = b;
            w    = {w[62:0], b};
        end
        return r;
    endfunction

    function automatic logic [63:0] mdl_adv(input logic [63:0] s);
        logic [63:0] w;
        logic        b;
        w = s;
        for (int i = 0; i < 8; i++) begin
            b = w[63] ^ w[62] ^ w[60] ^ w[59];
            w = {w[62:0], b};
        end
        return w;
    endfunction

    logic [63:0] m;
    logic [7:0]  hold;
    int          k;
    int          hs;

    initial begin
        n_cmp = 0;
        n_err = 0;
        if0.seed = '0; if0.seed_valid = 1'b0; if0.rnd_ready = 1'b0;
        if1.seed = '0; if1.seed_valid = 1'b0; if1.rnd_ready = 1'b0;
        if2.seed = '0; if2.seed_valid = 1'b0; if2.rnd_ready = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", if0.rnd_valid, 0);
        chk("rst_req", if0.reseed_req, 1);
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_valid", if0.rnd_valid, 0);
            chk("idle_req", if0.reseed_req, 1);
            chk("idle_sready", if0.seed_ready, 1);
            chk("idle_out", if0.rnd_out, 0);
            chk("idle_valid_wu", if1.rnd_valid, 0);
            chk("idle_state", dbg0, 0);
        end

        // No warmup: top-bit seed, continuous consumption, 1000 words
        if0.seed = 64'h8000_0000_0000_0000;
        if0.seed_valid = 1'b1;
        if0.rnd_ready = 1'b1;
        chk("pre_accept_valid", if0.rnd_valid, 0);
        tick();
        if0.seed_valid = 1'b0;
        chk("w0_valid", if0.rnd_valid, 1);
        chk("w0_req", if0.reseed_req, 0);
        chk("w0_word", if0.rnd_out, 8'h01);
        m = 64'h8000_0000_0000_0000;
        for (int i = 0; i < 1000; i++) begin
            if (i == 1) chk("w1_word", if0.rnd_out, 8'h00);
            chk("stream", if0.rnd_out, mdl_word(m));
            chk("stream_valid", if0.rnd_valid, 1);
            m = mdl_adv(m);
            tick();
        end
        if0.rnd_ready = 1'b0;

        // Seed accept together with a handshake
        chk("swap_old", if0.rnd_out, mdl_word(m));
        if0.seed = 64'h8000_0000_0000_0000;
        if0.seed_valid = 1'b1;
        if0.rnd_ready = 1'b1;
        tick();
        if0.seed_valid = 1'b0;
        chk("swap_new0", if0.rnd_out, 8'h01);
        tick();
        chk("swap_new1", if0.rnd_out, 8'h00);
        if0.rnd_ready = 1'b0;

        // Zero seed behaves as seed 1
        if0.seed = 64'h0;
        if0.seed_valid = 1'b1;
        tick();
        if0.seed_valid = 1'b0;
        if0.rnd_ready = 1'b1;
        m = 64'h1;
        for (int i = 0; i < 80; i++) begin
            chk("zero_seed", if0.rnd_out, mdl_word(m));
            m = mdl_adv(m);
            tick();
        end
        if0.rnd_ready = 1'b0;

        // Warmup of 4: latency, stall hold, first word after 32 steps
        if1.seed = 64'h1;
        if1.seed_valid = 1'b1;
        if1.rnd_ready = 1'b0;
        tick();
        if1.seed_valid = 1'b0;
        k = 1;
        while (!if1.rnd_valid && k < 20) begin
            tick();
            k++;
        end
        chk("wu_latency", k, 5);
        m = 64'h1;
        repeat (4) m = mdl_adv(m);
        chk("wu_first", if1.rnd_out, mdl_word(m));
        hold = if1.rnd_out;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("wu_hold", if1.rnd_out, hold);
            chk("wu_hold_valid", if1.rnd_valid, 1);
        end
        if1.rnd_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            chk("wu_stream", if1.rnd_out, mdl_word(m));
            m = mdl_adv(m);
            tick();
        end
        if1.rnd_ready = 1'b0;

        // Reseed budget of 3
        if2.seed = 64'h8000_0000_0000_0000;
        if2.seed_valid = 1'b1;
        if2.rnd_ready = 1'b1;
        tick();
        if2.seed_valid = 1'b0;
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            if (if2.rnd_valid) hs++;
            tick();
        end
        chk("budget_hs", hs, 3);
        chk("budget_valid", if2.rnd_valid, 0);
        chk("budget_req", if2.reseed_req, 1);
        m = 64'h8000_0000_0000_0000;
        repeat (3) m = mdl_adv(m);
        chk("budget_frozen", if2.rnd_out, mdl_word(m));
        if2.seed = 64'h8000_0000_0000_0000;
        if2.seed_valid = 1'b1;
        tick();
        if2.seed_valid = 1'b0;
        chk("reseed_valid", if2.rnd_valid, 1);
        chk("reseed_req", if2.reseed_req, 0);
        chk("reseed_word", if2.rnd_out, 8'h01);
        hs = 0;
        for (int i = 0; i < 8; i++) begin
            if (if2.rnd_valid) hs++;
            tick();
        end
        chk("reseed_hs", hs, 3);
        if2.rnd_ready = 1'b0;

        // Asynchronous reset mid-RUN
        if0.seed = 64'h8000_0000_0000_0000;
        if0.seed_valid = 1'b1;
        if0.rnd_ready = 1'b1;
        tick();
        if0.seed_valid = 1'b0;
        tick();
        chk("run_before_rst", if0.rnd_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", if0.rnd_valid, 0);
        chk("arst_req", if0.reseed_req, 1);
        chk("arst_out", if0.rnd_out, 0);
        chk("arst_state", dbg0, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_valid", if0.rnd_valid, 0);
        end
        if0.seed = 64'h8000_0000_0000_0000;
        if0.seed_valid = 1'b1;
        tick();
        if0.seed_valid = 1'b0;
        chk("post_rst_resume", if0.rnd_valid, 1);
        chk("post_rst_word", if0.rnd_out, 8'h01);
        if0.rnd_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
